fifo_rd_ptr_ctrl: RTL
=====================

# fifo_rd_ptr_ctrl

Parametrised read-side pointer controller for the asynchronous FIFO between the UART clock domains. It keeps a binary/Gray read pointer of depth 2^ADDR_WIDTH, compares it against the already-synchronised Gray write pointer, and produces registered empty, almost-empty and fill-level outputs. It replaces the fixed-depth read controller and adds occupancy reporting and an underflow monitor. It sits in the read clock domain, beside the dual-port RAM and the write-pointer two-flop synchroniser.

## Interface
- ADDR_WIDTH, 3: RAM address width; depth = 2^ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
- AEMPTY_THRESH, 1: raempty asserts when level <= this value; legal range 0..2^ADDR_WIDTH-1.
- R_CLK  in  1  read-domain clock, rising edge.
- R_RST  in  1  asynchronous reset, active-high.
- rinc  in  1  read request; accepted only when rempty=0.
- rq2_wptr  in  ADDR_WIDTH+1  Gray write pointer, already synchronised into R_CLK.
- undf_clr  in  1  clears the underflow status.
- raddr  out  ADDR_WIDTH  RAM read address.
- rptr  out  ADDR_WIDTH+1  registered Gray read pointer, sent to the write-domain synchroniser.
- rempty  out  1  registered empty flag.
- raempty  out  1  registered almost-empty flag.
- rlevel  out  ADDR_WIDTH+1  registered occupancy, 0..2^ADDR_WIDTH.
- rundf  out  1  sticky underflow flag.
- rundf_cnt  out  8  saturating underflow count.

## Operation
- State: rbin (ADDR_WIDTH+1 bits binary), rptr (Gray), rempty, raempty, rlevel, rundf, rundf_cnt.
- Accept: rd_ok = rinc & ~rempty. rbin_next = rbin + rd_ok, modulo 2^(ADDR_WIDTH+1); wrap from all-ones to 0 happens naturally, with no special-case compares.
- rgray_next = rbin_next ^ (rbin_next >> 1).
- raddr = rbin[ADDR_WIDTH-1:0], taken directly from the register.
- wbin = Gray-to-binary of rq2_wptr.
- level_next = wbin - rbin_next, computed at ADDR_WIDTH+1 bits, modulo.
- Registered updates each edge:
  - rptr <= rgray_next
  - rempty <= (rgray_next == rq2_wptr)
  - rlevel <= level_next
  - raempty <= (level_next <= AEMPTY_THRESH)
- Underflow event: rinc & rempty. Pointer is unchanged; the event is handled per Configuration.
- rempty is look-ahead. A read of the last word asserts rempty on the same edge that advances the pointer, so no extra read is possible.
- Simultaneous: the write pointer advancing on the same cycle as a read is reflected in the same update (level stays unchanged).
- Reset values: rbin=0, rptr=0, raddr=0, rempty=1, raempty=1, rlevel=0, rundf=0, rundf_cnt=0. Reset mid-transfer aborts immediately with no partial pointer value.

## Timing
- Single R_CLK domain. All outputs are registered except raddr, which is a direct slice of the register.
- Read latency: raddr is valid the cycle after the accept edge; RAM data timing is owned by the RAM.
- Write-side visibility: a change on rq2_wptr affects rempty, rlevel and raempty at the next R_CLK edge. The total write-to-not-empty latency is the 2 synchroniser cycles plus 1.
- rptr changes at most one bit per edge (Gray). This is required for a safe crossing.
- Release of R_RST is synchronised externally; the block assumes deassertion is clean with respect to R_CLK.

## Configuration
- FIFO_RD_UNDERFLOW_EN defined:
  - rundf sets on an underflow event.
  - rundf_cnt increments on each underflow event and saturates at 255.
  - undf_clr clears both. If undf_clr and an event occur in the same cycle, clear wins and the count becomes 0.
- Not defined: rundf and rundf_cnt are tied to 0, undf_clr is ignored, and no status registers are inferred.

## Structure
- Shared package fifo_pkg holds:
  - the gray2bin and bin2gray functions
  - the default ADDR_WIDTH and AEMPTY_THRESH constants
  - the underflow counter width constant (8)
- One sub-module: gray2bin_conv, the parametrised combinational Gray-to-binary converter. The write-side controller reuses it.

## Test plan
1. Reset, ADDR_WIDTH=3: assert R_RST mid-run -> rempty=1, raempty=1, rlevel=0, rptr=0, raddr=0 immediately (asynchronous).
2. Drive rq2_wptr to Gray(5)=4'b0111 with rinc=0 -> next edge: rempty=0, rlevel=5, raempty=0 (AEMPTY_THRESH=1). Then 4 reads -> rlevel=1, raempty=1. Then 1 read -> rempty=1, rlevel=0.
3. Wrap: issue 20 write/read pairs across the pointer roll-over from 15 to 0 -> raddr cycles 0..7, rptr changes exactly one bit per accepted read, and there is no false empty.
4. Full: rq2_wptr=Gray(8) with rbin=0 -> rlevel=8, rempty=0, raempty=0.
5. Underflow with macro on: rinc=1 while empty for 3 cycles -> pointer frozen, rundf=1, rundf_cnt=3. Undf_clr and an event in the same cycle -> count=0. 300 events -> count=255. Macro off: both outputs stay 0.
6. Simultaneous: rlevel=3, and a read coincides with rq2_wptr advancing by one -> rlevel stays 3 and rempty stays 0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO pointer controllers: default geometry,
// underflow counter width and Gray/binary conversion helpers.
package fifo_pkg;

    localparam int unsigned ADDR_WIDTH_DEF    = 3;
    localparam int unsigned AEMPTY_THRESH_DEF = 1;
    localparam int unsigned UNDF_CNT_W        = 8;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Parametrised combinational Gray-to-binary converter, shared by the read-
// and write-side FIFO pointer controllers.
module gray2bin_conv #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] gray_i,
    output logic [W-1:0] bin_o
);

    // Each binary bit is the XOR of all Gray bits at or above its position.
    always_comb begin
        bin_o = '0;
        for (int unsigned i = 0; i < W; i++) begin
            bin_o[i] = ^(gray_i >> i);
        end
    end

endmodule

// File: rtl/fifo_rd_ptr_ctrl.sv
// Read-side pointer controller for the async FIFO: Gray read pointer, look-ahead
// empty, almost-empty and fill level. Underflow monitor under FIFO_RD_UNDERFLOW_EN.
module fifo_rd_ptr_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH    = ADDR_WIDTH_DEF,
    parameter int unsigned AEMPTY_THRESH = AEMPTY_THRESH_DEF
) (
    input  logic                  R_CLK,
    input  logic                  R_RST,
    input  logic                  rinc,
    input  logic [ADDR_WIDTH:0]   rq2_wptr,
    input  logic                  undf_clr,
    output logic [ADDR_WIDTH-1:0] raddr,
    output logic [ADDR_WIDTH:0]   rptr,
    output logic                  rempty,
    output logic                  raempty,
    output logic [ADDR_WIDTH:0]   rlevel,
    output logic                  rundf,
    output logic [UNDF_CNT_W-1:0] rundf_cnt
);

    localparam int unsigned   PW     = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] THRESH = PW'(AEMPTY_THRESH);

    logic [PW-1:0] rbin_q, rbin_d;
    logic [PW-1:0] rptr_q, rgray_d;
    logic [PW-1:0] rlevel_q, level_d;
    logic          rempty_q, raempty_q;
    logic [PW-1:0] wbin;
    logic          rd_ok;

    gray2bin_conv #(.W(PW)) u_wptr_g2b (
        .gray_i (rq2_wptr),
        .bin_o  (wbin)
    );

    // Level is taken against the post-read pointer so a read and a write
    // landing on the same edge leave the level unchanged.
    always_comb begin
        rd_ok   = rinc & ~rempty_q;
        rbin_d  = rbin_q + {{ADDR_WIDTH{1'b0}}, rd_ok};
        rgray_d = PW'(bin2gray(32'(rbin_d)));
        level_d = wbin - rbin_d;
    end

    always_ff @(posedge R_CLK or posedge R_RST) begin
        if (R_RST) begin
            rbin_q    <= '0;
            rptr_q    <= '0;
            rempty_q  <= 1'b1;
            raempty_q <= 1'b1;
            rlevel_q  <= '0;
        end else begin
            rbin_q    <= rbin_d;
            rptr_q    <= rgray_d;
            rempty_q  <= (rgray_d == rq2_wptr);
            raempty_q <= (level_d <= THRESH);
            rlevel_q  <= level_d;
        end
    end

    assign raddr   = rbin_q[ADDR_WIDTH-1:0];
    assign rptr    = rptr_q;
    assign rempty  = rempty_q;
    assign raempty = raempty_q;
    assign rlevel  = rlevel_q;

`ifdef FIFO_RD_UNDERFLOW_EN
    logic                  undf_ev;
    logic                  rundf_q, rundf_d;
    logic [UNDF_CNT_W-1:0] ucnt_q, ucnt_d;

    // Clear has priority over a coincident underflow event.
    always_comb begin
        undf_ev = rinc & rempty_q;
        rundf_d = rundf_q;
        ucnt_d  = ucnt_q;
        if (undf_clr) begin
            rundf_d = 1'b0;
            ucnt_d  = '0;
        end else if (undf_ev) begin
            rundf_d = 1'b1;
            if (ucnt_q != '1) begin
                ucnt_d = ucnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge R_CLK or posedge R_RST) begin
        if (R_RST) begin
            rundf_q <= 1'b0;
            ucnt_q  <= '0;
        end else begin
            rundf_q <= rundf_d;
            ucnt_q  <= ucnt_d;
        end
    end

    assign rundf     = rundf_q;
    assign rundf_cnt = ucnt_q;
`else
    logic unused_undf_clr;
    assign unused_undf_clr = undf_clr;
    assign rundf           = 1'b0;
    assign rundf_cnt       = '0;
`endif

endmodule
